// File: rtl/of_pkg.sv
// Shared types and size codes for the operand-fetch stage.
// Optional build macro OF_BYPASS_EN is consumed by of_stage, not here.
package of_pkg;

  typedef enum logic [1:0] {
    REGISTER = 2'd0,
    MEMORY   = 2'd1,
    IMM      = 2'd2
  } operand_t;

  typedef enum logic [3:0] {
    RAX = 4'd0,  RCX = 4'd1,  RDX = 4'd2,  RBX = 4'd3,
    RSP = 4'd4,  RBP = 4'd5,  RSI = 4'd6,  RDI = 4'd7,
    R8  = 4'd8,  R9  = 4'd9,  R10 = 4'd10, R11 = 4'd11,
    R12 = 4'd12, R13 = 4'd13, R14 = 4'd14, R15 = 4'd15
  } regname;

  localparam logic [1:0] SZ_8  = 2'b00;
  localparam logic [1:0] SZ_16 = 2'b01;
  localparam logic [1:0] SZ_32 = 2'b10;
  localparam logic [1:0] SZ_64 = 2'b11;

  function automatic logic [63:0] size_mask64(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SZ_8:    m = 64'h0000_0000_0000_00FF;
      SZ_16:   m = 64'h0000_0000_0000_FFFF;
      SZ_32:   m = 64'h0000_0000_FFFF_FFFF;
      SZ_64:   m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/of_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register.
// A set and a clear of the same register on one edge leaves the bit set.
module of_scoreboard
#(
  parameter int NREGS = 16,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [RW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [RW-1:0]    clr_idx,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_nxt_s;

  // next busy vector, set has priority over clear
  always_comb begin
    busy_nxt_s = busy;
    for (int i = 0; i < NREGS; i++) begin
      busy_nxt_s[i] = (set_en && (set_idx == RW'(i))) ? 1'b1 :
                      (clr_en && (clr_idx == RW'(i))) ? 1'b0 : busy[i];
    end
  end

  // busy register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt_s;
    end
  end

endmodule

// File: rtl/of_stage.sv
// Operand-fetch stage: hazard check, operand read/mask and a one-entry output register.
// Define OF_BYPASS_EN to forward same-cycle writeback data instead of stalling.
module of_stage
  import of_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 16,
  parameter int OPW   = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREGS-1:0][XLEN-1:0] regx,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPW-1:0]             in_op,
  input  operand_t                   in_srcty,
  input  logic [XLEN-1:0]            in_srcval,
  input  logic [RW-1:0]              in_dstreg,
  input  logic [1:0]                 in_size,
  input  logic                       in_wr,
  input  logic                       wb_valid,
  input  logic [RW-1:0]              wb_reg,
  input  logic [XLEN-1:0]            wb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPW-1:0]             out_op,
  output logic [RW-1:0]              out_dstreg,
  output logic [XLEN-1:0]            out_oper1,
  output logic [XLEN-1:0]            out_oper2,
  output logic [1:0]                 out_size,
  output logic                       out_wr,
  output logic [31:0]                stall_cnt
);

  logic [NREGS-1:0] busy_s;
  logic [NREGS-1:0] wb_hit_s;
  logic [NREGS-1:0] busy_eff_s;
  logic [RW-1:0]    src_idx_s;
  logic             hazard_s;
  logic             accept_s;
  logic             stall_s;
  logic [XLEN-1:0]  mask_s;
  logic [XLEN-1:0]  oper1_s;
  logic [XLEN-1:0]  oper2_s;

  assign src_idx_s = in_srcval[RW-1:0];

`ifdef OF_BYPASS_EN
  // one-hot of the register being retired this cycle
  always_comb begin
    wb_hit_s         = '0;
    wb_hit_s[wb_reg] = wb_valid;
  end
`else
  assign wb_hit_s = '0;
`endif

  assign busy_eff_s = busy_s & ~wb_hit_s;
  assign hazard_s   = busy_eff_s[in_dstreg] |
                      ((in_srcty == REGISTER) & busy_eff_s[src_idx_s]);
  assign in_ready   = (~out_valid | out_ready) & ~hazard_s;
  assign accept_s   = in_valid & in_ready;
  assign stall_s    = in_valid & ~in_ready;
  assign mask_s     = XLEN'(size_mask64(in_size));

  // operand selection with optional forwarding, masked to the size code
  always_comb begin
    oper1_s = wb_hit_s[in_dstreg] ? wb_data : regx[in_dstreg];
    case (in_srcty)
      REGISTER:    oper2_s = wb_hit_s[src_idx_s] ? wb_data : regx[src_idx_s];
      MEMORY, IMM: oper2_s = in_srcval;
      default:     oper2_s = in_srcval;
    endcase
    oper1_s = oper1_s & mask_s;
    oper2_s = oper2_s & mask_s;
  end

  // output register: load on accept, drop valid once consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_op     <= '0;
      out_dstreg <= '0;
      out_oper1  <= '0;
      out_oper2  <= '0;
      out_size   <= 2'b00;
      out_wr     <= 1'b0;
    end else if (accept_s) begin
      out_valid  <= 1'b1;
      out_op     <= in_op;
      out_dstreg <= in_dstreg;
      out_oper1  <= oper1_s;
      out_oper2  <= oper2_s;
      out_size   <= in_size;
      out_wr     <= in_wr;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // saturating stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall_s && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  of_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept_s & in_wr),
    .set_idx (in_dstreg),
    .clr_en  (wb_valid),
    .clr_idx (wb_reg),
    .busy    (busy_s)
  );

endmodule

// File: tb/tb_of_stage.sv
// Self-checking bench for of_stage: directed scenarios then random traffic
// checked against a cycle-level behavioural model (honours OF_BYPASS_EN).
module tb_of_stage;
  import of_pkg::*;

  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int OPW   = 8;
  localparam int RW    = 4;
`ifdef OF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NREGS-1:0][XLEN-1:0] regx;
  logic                       in_valid, in_ready;
  logic [OPW-1:0]             in_op;
  operand_t                   in_srcty;
  logic [XLEN-1:0]            in_srcval;
  logic [RW-1:0]              in_dstreg;
  logic [1:0]                 in_size;
  logic                       in_wr;
  logic                       wb_valid;
  logic [RW-1:0]              wb_reg;
  logic [XLEN-1:0]            wb_data;
  logic                       out_valid, out_ready;
  logic [OPW-1:0]             out_op;
  logic [RW-1:0]              out_dstreg;
  logic [XLEN-1:0]            out_oper1, out_oper2;
  logic [1:0]                 out_size;
  logic                       out_wr;
  logic [31:0]                stall_cnt;

  of_stage #(.XLEN(XLEN), .NREGS(NREGS), .OPW(OPW)) dut (
    .clk(clk), .reset(reset), .regx(regx),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_srcty(in_srcty),
    .in_srcval(in_srcval), .in_dstreg(in_dstreg), .in_size(in_size), .in_wr(in_wr),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_dstreg(out_dstreg), .out_oper1(out_oper1), .out_oper2(out_oper2),
    .out_size(out_size), .out_wr(out_wr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit              m_busy [NREGS];
  logic [XLEN-1:0] regs   [NREGS];
  bit              m_ov;
  logic [OPW-1:0]  m_op;
  logic [RW-1:0]   m_dst;
  logic [63:0]     m_o1, m_o2;
  logic [1:0]      m_size;
  bit              m_wr;
  logic [31:0]     m_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sized(input logic [63:0] v, input logic [1:0] sz);
    int bits;
    bits = 8 << sz;
    if (bits >= 64) return v;
    return v & ((64'd1 << bits) - 64'd1);
  endfunction

  function automatic bit fwd(input int r);
    return BYP && wb_valid && (int'(wb_reg) == r);
  endfunction

  function automatic bit blocked(input int r);
    return m_busy[r] && !fwd(r);
  endfunction

  function automatic logic [63:0] reg_val(input int r);
    return fwd(r) ? wb_data : regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    m_ov = 1'b0; m_op = '0; m_dst = '0; m_o1 = '0; m_o2 = '0;
    m_size = 2'b00; m_wr = 1'b0; m_stall = 32'd0;
  endtask

  task automatic set_in(input bit v, input logic [7:0] op, input operand_t ty,
                        input logic [63:0] val, input logic [3:0] dst,
                        input logic [1:0] sz, input bit wr);
    in_valid = v; in_op = op; in_srcty = ty; in_srcval = val;
    in_dstreg = dst; in_size = sz; in_wr = wr;
  endtask

  task automatic set_wb(input bit v, input logic [3:0] r, input logic [63:0] d);
    wb_valid = v; wb_reg = r; wb_data = d;
  endtask

  task automatic check_outputs();
    check("out_valid",  out_valid,  m_ov);
    check("out_op",     out_op,     m_op);
    check("out_dstreg", out_dstreg, m_dst);
    check("out_oper1",  out_oper1,  m_o1);
    check("out_oper2",  out_oper2,  m_o2);
    check("out_size",   out_size,   m_size);
    check("out_wr",     out_wr,     m_wr);
    check("stall_cnt",  stall_cnt,  m_stall);
  endtask

  // one clock: inputs were set after the previous edge; check ready, advance model
  task automatic step();
    bit hz, rdy, acc, wbv;
    int src, dst;
    logic [3:0]  wbr;
    logic [63:0] wbd;
    @(negedge clk);
    src = int'(in_srcval[RW-1:0]);
    dst = int'(in_dstreg);
    hz  = blocked(dst) || ((in_srcty == REGISTER) && blocked(src));
    rdy = (!m_ov || out_ready) && !hz;
    acc = in_valid && rdy;
    check("in_ready", in_ready, rdy);
    if (in_valid && !rdy && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
    if (acc) begin
      m_ov = 1'b1; m_op = in_op; m_dst = in_dstreg; m_size = in_size; m_wr = in_wr;
      m_o1 = sized(reg_val(dst), in_size);
      m_o2 = sized((in_srcty == REGISTER) ? reg_val(src) : in_srcval, in_size);
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (wb_valid) m_busy[wb_reg] = 1'b0;
    if (acc && in_wr) m_busy[dst] = 1'b1;
    wbv = wb_valid; wbr = wb_reg; wbd = wb_data;
    @(posedge clk);
    #1;
    if (wbv) begin
      regs[wbr] = wbd;
      regx[wbr] = wbd;
    end
    check_outputs();
  endtask

  initial begin
    logic [31:0] base;
    int pick [$];
    reset = 1'b1;
    set_in(1'b0, 8'h00, IMM, 64'd0, 4'd0, 2'b00, 1'b0);
    set_wb(1'b0, 4'd0, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      regs[i] = {$urandom, $urandom};
      regx[i] = regs[i];
    end
    regs[RAX] = 64'hFFFF_0000_0000_AAAA;
    regx[RAX] = regs[RAX];
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_stall_cnt", stall_cnt, 64'd0);
    check("rst_out_oper1", out_oper1, 64'd0);

    // first cycle out of reset: ADD RAX, imm, size 16
    reset = 1'b0;
    set_in(1'b1, 8'h01, IMM, 64'h1234_5678_9ABC_DEF0, RAX, 2'b01, 1'b0);
    step();
    check("add_oper1", out_oper1, 64'h0000_0000_0000_AAAA);
    check("add_oper2", out_oper2, 64'h0000_0000_0000_DEF0);
    check("add_valid", out_valid, 64'd1);

    // write RBX, then a reader of RBX stalls until writeback
    set_in(1'b1, 8'h02, IMM, 64'h7, RBX, 2'b11, 1'b1);
    step();
    set_in(1'b1, 8'h03, REGISTER, 64'(RBX), RCX, 2'b00, 1'b0);
    base = stall_cnt;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("rbx_stall_cnt", stall_cnt, 64'(base + 32'(k)));
      check("rbx_stall_ready", in_ready, 64'd0);
    end
    set_wb(1'b1, RBX, 64'h55);
    step();
    set_wb(1'b0, 4'd0, 64'd0);
`ifdef OF_BYPASS_EN
    check("byp_oper2", out_oper2, 64'h55);
    check("byp_stall_cnt", stall_cnt, 64'(base + 32'd3));
`else
    check("nobyp_stall_cnt", stall_cnt, 64'(base + 32'd4));
    step();
    check("nobyp_oper2", out_oper2, 64'h55);
`endif

    // downstream backpressure for three cycles
    out_ready = 1'b0;
    set_in(1'b1, 8'h04, IMM, 64'h1122, RDX, 2'b01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_oper2", out_oper2, 64'h55);
      check("hold_dst", out_dstreg, 64'(RCX));
    end
    out_ready = 1'b1;
    step();
    check("release_oper2", out_oper2, 64'h1122);
    check("release_dst", out_dstreg, 64'(RDX));
    set_in(1'b0, 8'h00, IMM, 64'd0, 4'd0, 2'b00, 1'b0);
    step();
    check("drain_valid", out_valid, 64'd0);

    // set and clear RCX on the same edge: set wins
    set_in(1'b1, 8'h05, IMM, 64'd0, RCX, 2'b00, 1'b1);
    set_wb(1'b1, RCX, 64'h99);
    step();
    set_wb(1'b0, 4'd0, 64'd0);
    set_in(1'b1, 8'h06, REGISTER, 64'(RCX), RDX, 2'b00, 1'b0);
    step();
    check("rcx_still_busy", in_ready, 64'd0);
    step();
    // asynchronous reset in the middle of a stall
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_valid", out_valid, 64'd0);
    check("mid_rst_stall", stall_cnt, 64'd0);
    check("mid_rst_op", out_op, 64'd0);
    check("mid_rst_busy_clear", in_ready, 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // random traffic
    for (int c = 0; c < 600; c++) begin
      set_in($urandom_range(0, 3) != 0, 8'($urandom), operand_t'($urandom_range(0, 2)),
             {$urandom, $urandom}, 4'($urandom_range(0, NREGS - 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        pick.delete();
        for (int i = 0; i < NREGS; i++) if (m_busy[i]) pick.push_back(i);
        if (pick.size() > 0)
          set_wb(1'b1, 4'(pick[$urandom_range(0, pick.size() - 1)]), {$urandom, $urandom});
        else
          set_wb(1'b1, 4'($urandom_range(0, NREGS - 1)), {$urandom, $urandom});
      end else begin
        set_wb(1'b0, 4'd0, 64'd0);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
